// File: rtl/e_mdu.sv
// ---------------------------------------------------------------------------
// e_mdu -- multiply/divide unit of the E stage.
//
// Executes mult, multu, div, divu, mthi and mtlo and holds the architectural
// HI/LO registers. A mult/div result is computed when the op is accepted and
// parked in tmp_hi/tmp_lo. It is committed to HI/LO after a fixed number of
// busy cycles. While busy, every incoming op is ignored. The hazard unit
// stalls D on busy, so in normal operation no op is dropped.
//
// Parameters:
//   MULT_CYCLES  busy cycles for mult/multu (1..15)
//   DIV_CYCLES   busy cycles for div/divu   (1..15)
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-high reset
//   op_valid  one-cycle strobe: E-stage instruction is an MDU op
//   md_op     0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   rs_val    forwarded rs operand (multiplicand / dividend / move source)
//   rt_val    forwarded rt operand (multiplier / divisor)
//   hi, lo    architectural HI/LO (registered)
//   busy      a mult/div result is pending (registered)
// ---------------------------------------------------------------------------
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_nx_s;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic [3:0]  cnt_r;
    logic [31:0] tmp_hi_r;
    logic [31:0] tmp_lo_r;
    logic        dz_r;       // pending op is a divide by zero: do not commit

    logic [31:0] hi_nx_s;
    logic [31:0] lo_nx_s;
    logic        busy_nx_s;
    logic [3:0]  cnt_nx_s;
    logic [31:0] tmp_hi_nx_s;
    logic [31:0] tmp_lo_nx_s;
    logic        dz_nx_s;
    logic [63:0] prod_s;
    logic [63:0] divres_s;

    // 64-bit product; signed operands are sign-extended so the low 64 bits
    // of the product are correct for both signednesses.
    function automatic logic [63:0] mul_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        if (sgn) begin
            ea = {{32{a[31]}}, a};
            eb = {{32{b[31]}}, b};
        end else begin
            ea = {32'd0, a};
            eb = {32'd0, b};
        end
        return ea * eb;
    endfunction

    // Division on magnitudes, then sign fix-up: quotient negative when the
    // operand signs differ, remainder follows the dividend. The magnitude of
    // 0x80000000 is 0x80000000 unsigned, so min/-1 naturally yields
    // quotient 0x80000000, remainder 0. Returns {remainder, quotient}.
    function automatic logic [63:0] div_calc(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic        sgn);
        logic        neg_q;
        logic        neg_r;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_q = sgn & (a[31] ^ b[31]);
        neg_r = sgn & a[31];
        if (sgn && a[31]) begin
            ma = 32'd0 - a;
        end else begin
            ma = a;
        end
        if (sgn && b[31]) begin
            mb = 32'd0 - b;
        end else begin
            mb = b;
        end
        // A zero divisor's result is never committed; avoid dividing by it.
        if (mb == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ma / mb;
            r = ma % mb;
        end
        if (neg_q) begin
            q = 32'd0 - q;
        end else begin
            q = q;
        end
        if (neg_r) begin
            r = 32'd0 - r;
        end else begin
            r = r;
        end
        return {r, q};
    endfunction

    // Next-state and datapath: accept in IDLE, count down and commit in RUN.
    always_comb begin
        state_nx_s  = state_r;
        hi_nx_s     = hi_r;
        lo_nx_s     = lo_r;
        cnt_nx_s    = cnt_r;
        tmp_hi_nx_s = tmp_hi_r;
        tmp_lo_nx_s = tmp_lo_r;
        dz_nx_s     = dz_r;
        prod_s      = mul_calc(rs_val, rt_val, md_op == OP_MULT);
        divres_s    = div_calc(rs_val, rt_val, md_op == OP_DIV);

        case (state_r)
            ST_IDLE: begin
                if (op_valid) begin
                    case (md_op)
                        OP_MULT, OP_MULTU: begin
                            tmp_hi_nx_s = prod_s[63:32];
                            tmp_lo_nx_s = prod_s[31:0];
                            cnt_nx_s    = MULT_CNT;
                            dz_nx_s     = 1'b0;
                            state_nx_s  = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            tmp_hi_nx_s = divres_s[63:32];
                            tmp_lo_nx_s = divres_s[31:0];
                            cnt_nx_s    = DIV_CNT;
                            dz_nx_s     = (rt_val == 32'd0);
                            state_nx_s  = ST_RUN;
                        end
                        OP_MTHI: begin
                            hi_nx_s    = rs_val;
                            state_nx_s = ST_IDLE;
                        end
                        OP_MTLO: begin
                            lo_nx_s    = rs_val;
                            state_nx_s = ST_IDLE;
                        end
                        default: begin
                            state_nx_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Incoming ops are ignored here.
                cnt_nx_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    state_nx_s = ST_IDLE;
                    if (!dz_r) begin
                        hi_nx_s = tmp_hi_r;
                        lo_nx_s = tmp_lo_r;
                    end else begin
                        hi_nx_s = hi_r;
                        lo_nx_s = lo_r;
                    end
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase

        busy_nx_s = (state_nx_s == ST_RUN);
    end

    // State register; reset aborts any pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            hi_r     <= 32'd0;
            lo_r     <= 32'd0;
            busy_r   <= 1'b0;
            cnt_r    <= 4'd0;
            tmp_hi_r <= 32'd0;
            tmp_lo_r <= 32'd0;
            dz_r     <= 1'b0;
        end else begin
            state_r  <= state_nx_s;
            hi_r     <= hi_nx_s;
            lo_r     <= lo_nx_s;
            busy_r   <= busy_nx_s;
            cnt_r    <= cnt_nx_s;
            tmp_hi_r <= tmp_hi_nx_s;
            tmp_lo_r <= tmp_lo_nx_s;
            dz_r     <= dz_nx_s;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;

endmodule

// File: tb/tb_e_mdu.sv
// ---------------------------------------------------------------------------
// tb_e_mdu -- self-checking bench for e_mdu.
// Directed cases from the feature list plus a randomized sequence. Expected
// HI/LO come from a 64-bit arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_e_mdu;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int          tests;
    int          fails;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk      (clk),
        .reset    (reset),
        .op_valid (op_valid),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .hi       (hi),
        .lo       (lo),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int cycles_for(input logic [2:0] op);
        case (op)
            3'd1, 3'd2: return MC;
            3'd3, 3'd4: return DC;
            default:    return 0;
        endcase
    endfunction

    // Reference model: architectural effect of an accepted op on HI/LO.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint          p;
        longint unsigned u;
        case (op)
            3'd1: begin
                p = longint'($signed(a)) * longint'($signed(b));
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            3'd2: begin
                u = 64'(a) * 64'(b);
                exp_hi = u[63:32];
                exp_lo = u[31:0];
            end
            3'd3: begin
                if (b != 32'd0) begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    exp_lo = 32'(sa / sb);
                    exp_hi = 32'(sa % sb);
                end
            end
            3'd4: begin
                if (b != 32'd0) begin
                    exp_lo = 32'(64'(a) / 64'(b));
                    exp_hi = 32'(64'(a) % 64'(b));
                end
            end
            3'd5: exp_hi = a;
            3'd6: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue op at the current negedge; optionally strobe another op during
    // busy cycle 'inj'. Checks busy and stale HI/LO every busy cycle, then
    // the committed result. Returns at the negedge of cycle T+N+1.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int inj, input logic [2:0] inj_op,
                          input logic [31:0] ia, input logic [31:0] ib);
        int          n;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        n      = cycles_for(op);
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, a, b);
        op_valid = 1'b1;
        md_op    = op;
        rs_val   = a;
        rt_val   = b;
        @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            check({tag, " busy"}, {31'd0, busy}, 32'd1);
            check({tag, " stale hi"}, hi, old_hi);
            check({tag, " stale lo"}, lo, old_lo);
            if (i == inj) begin
                op_valid = 1'b1;
                md_op    = inj_op;
                rs_val   = ia;
                rt_val   = ib;
            end else begin
                op_valid = 1'b0;
                md_op    = 3'd0;
            end
            @(negedge clk);
        end
        op_valid = 1'b0;
        md_op    = 3'd0;
        check({tag, " busy done"}, {31'd0, busy}, 32'd0);
        check({tag, " hi"}, hi, exp_hi);
        check({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  ops [6];
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rinj;

        tests    = 0;
        fails    = 0;
        exp_hi   = 32'd0;
        exp_lo   = 32'd0;
        reset    = 1'b1;
        op_valid = 1'b0;
        md_op    = 3'd0;
        rs_val   = 32'd0;
        rt_val   = 32'd0;
        ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd3;
        ops[3] = 3'd4; ops[4] = 3'd5; ops[5] = 3'd6;

        repeat (2) @(negedge clk);
        check("reset hi", hi, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Signed / unsigned multiply
        run_op("mult", 3'd1, 32'hFFFFFFFF, 32'd2, 0, 3'd0, 32'd0, 32'd0);
        check("mult hi const", hi, 32'hFFFFFFFF);
        check("mult lo const", lo, 32'hFFFFFFFE);
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 0, 3'd0, 32'd0, 32'd0);
        check("multu hi const", hi, 32'h00000001);
        check("multu lo const", lo, 32'hFFFFFFFE);

        // Signed / unsigned divide, signed overflow
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 0, 3'd0, 32'd0, 32'd0);
        check("div lo const", lo, 32'hFFFFFFFD);
        check("div hi const", hi, 32'hFFFFFFFF);
        run_op("divu", 3'd4, 32'd7, 32'd2, 0, 3'd0, 32'd0, 32'd0);
        check("divu lo const", lo, 32'd3);
        check("divu hi const", hi, 32'd1);
        run_op("div ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 0, 3'd0, 32'd0, 32'd0);
        check("div ovf lo const", lo, 32'h80000000);
        check("div ovf hi const", hi, 32'd0);

        // Divide by zero keeps preloaded HI/LO
        run_op("mthi pre", 3'd5, 32'h11, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        run_op("mtlo pre", 3'd6, 32'h22, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        run_op("div0", 3'd3, 32'd5, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        check("div0 hi const", hi, 32'h11);
        check("div0 lo const", lo, 32'h22);

        // Moves
        run_op("mthi", 3'd5, 32'h1234, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        check("mthi const", hi, 32'h1234);
        run_op("mtlo in busy", 3'd1, 32'd6, 32'd7, 3, 3'd6, 32'hDEAD, 32'd0);
        check("mtlo in busy lo const", lo, 32'd42);

        // Second MULT strobed in busy cycle 2 is ignored
        run_op("ignore", 3'd1, 32'd2, 32'd2, 2, 3'd1, 32'd3, 32'd3);
        check("ignore lo const", lo, 32'd4);
        check("ignore hi const", hi, 32'd0);

        // Randomized sequence, back-to-back, with random ignored strobes
        for (int k = 0; k < 40; k++) begin
            rop = ops[$urandom_range(0, 5)];
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 7) == 0) begin
                rb = 32'd0;
            end
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            rinj = (cycles_for(rop) > 0) ? int'($urandom_range(0, cycles_for(rop))) : 0;
            run_op("rand", rop, ra, rb, rinj, 3'($urandom_range(1, 6)), $urandom, $urandom);
        end

        // Reset in busy cycle 3 of DIVU 100/7 discards everything
        run_op("mthi pre2", 3'd5, 32'hAAAA, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        run_op("mtlo pre2", 3'd6, 32'h5555, 32'd0, 0, 3'd0, 32'd0, 32'd0);
        op_valid = 1'b1;
        md_op    = 3'd4;
        rs_val   = 32'd100;
        rt_val   = 32'd7;
        @(negedge clk);
        op_valid = 1'b0;
        md_op    = 3'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst mid hi", hi, 32'd0);
        check("rst mid lo", lo, 32'd0);
        check("rst mid busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("rst after hi", hi, 32'd0);
            check("rst after lo", lo, 32'd0);
            check("rst after busy", {31'd0, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
